// File: rtl/branch_redirect_controller.sv
// Branch/jump redirect sequencer: registered PC redirect plus 3-stage flush.
// Optional BRANCH_STATS_EN builds saturating resolved/taken branch counters.
module branch_redirect_controller #(
  parameter int STATS_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   EX_VALID,
  input  logic [3:0]             BRANCH_SELECT,
  input  logic                   BRANCH_TAKEN,
  input  logic [31:0]            EX_TARGET,
  input  logic                   STALL,
  output logic                   REDIRECT,
  output logic [31:0]            REDIRECT_PC,
  output logic [2:0]             FLUSH,
  output logic                   MISALIGNED,
  output logic [STATS_WIDTH-1:0] BR_COUNT,
  output logic [STATS_WIDTH-1:0] BR_TAKEN_COUNT
);

  typedef enum logic {
    IDLE,
    REDIR
  } state_t;

  state_t state, state_n;
  logic   is_br;
  logic   resolve;
  logic   taken;
  logic   mis_q;
  logic   [31:0] pc_q;
  logic   unused_tgt0;

  // bit0 of the target is always cleared, so it never reaches state
  assign unused_tgt0 = EX_TARGET[0];

  // funct3 011 under bit3 is a reserved encoding, not a branch
  always_comb begin
    is_br = BRANCH_SELECT[3] &&
            (BRANCH_SELECT[2:0] != 3'b011);
  end

  // EX is only trusted in IDLE; in REDIRECT it holds wrong-path work
  always_comb begin
    resolve = (state == IDLE) && !STALL &&
              EX_VALID && is_br;
    taken   = resolve && BRANCH_TAKEN;
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // next state: fire on taken, leave on the first unstalled edge
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (taken)  state_n = REDIR;
      REDIR:   if (!STALL) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // latch target on fire; misaligned flag lives only while redirecting
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q  <= 32'h0;
      mis_q <= 1'b0;
    end else if (taken) begin
      pc_q  <= {EX_TARGET[31:1], 1'b0};
      mis_q <= EX_TARGET[1];
    end else if (state_n == IDLE) begin
      mis_q <= 1'b0;
    end
  end

  assign REDIRECT    = (state == REDIR);
  assign FLUSH       = {3{state == REDIR}};
  assign REDIRECT_PC = pc_q;
  assign MISALIGNED  = mis_q;

`ifdef BRANCH_STATS_EN
  logic [STATS_WIDTH-1:0] br_cnt_q;
  logic [STATS_WIDTH-1:0] tk_cnt_q;

  // saturating counters, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      if (resolve && (br_cnt_q != '1))
        br_cnt_q <= br_cnt_q + 1'b1;
      if (taken && (tk_cnt_q != '1))
        tk_cnt_q <= tk_cnt_q + 1'b1;
    end
  end

  assign BR_COUNT       = br_cnt_q;
  assign BR_TAKEN_COUNT = tk_cnt_q;
`else
  assign BR_COUNT       = '0;
  assign BR_TAKEN_COUNT = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Bench for branch_redirect_controller: directed vectors,
// a per-cycle reference model and literal spot checks.
module tb_branch_redirect_controller;

  localparam int SW   = 4;
  localparam int MAXC = (1 << SW) - 1;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          EX_VALID = 1'b0;
  logic [3:0]    BRANCH_SELECT = 4'h0;
  logic          BRANCH_TAKEN = 1'b0;
  logic [31:0]   EX_TARGET = 32'h0;
  logic          STALL = 1'b0;
  logic          REDIRECT;
  logic [31:0]   REDIRECT_PC;
  logic [2:0]    FLUSH;
  logic          MISALIGNED;
  logic [SW-1:0] BR_COUNT;
  logic [SW-1:0] BR_TAKEN_COUNT;

  int n_chk  = 0;
  int n_pass = 0;

  branch_redirect_controller #(.STATS_WIDTH(SW)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .EX_VALID(EX_VALID),
    .BRANCH_SELECT(BRANCH_SELECT),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .EX_TARGET(EX_TARGET),
    .STALL(STALL),
    .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .FLUSH(FLUSH),
    .MISALIGNED(MISALIGNED),
    .BR_COUNT(BR_COUNT),
    .BR_TAKEN_COUNT(BR_TAKEN_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, a, e);
  endtask

  // reference: what the pipeline must see after each edge
  bit        started = 0;
  bit        m_busy;
  bit [31:0] m_pc;
  bit        m_mis;
  int        m_bc;
  int        m_tc;

  // model update from the spec's rules at every rising edge
  always @(posedge CLK) begin
    if (RESET) begin
      started <= 1'b1;
      m_busy  <= 1'b0;
      m_pc    <= 32'h0;
      m_mis   <= 1'b0;
      m_bc    <= 0;
      m_tc    <= 0;
    end else if (m_busy) begin
      if (!STALL) begin
        m_busy <= 1'b0;
        m_mis  <= 1'b0;
      end
    end else if (!STALL && EX_VALID && BRANCH_SELECT[3] &&
                 BRANCH_SELECT[2:0] != 3'b011) begin
      m_bc <= (m_bc < MAXC) ? m_bc + 1 : m_bc;
      if (BRANCH_TAKEN) begin
        m_busy <= 1'b1;
        m_pc   <= EX_TARGET & 32'hFFFF_FFFE;
        m_mis  <= EX_TARGET[1];
        m_tc   <= (m_tc < MAXC) ? m_tc + 1 : m_tc;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge CLK) begin
    if (started) begin
      chk("m_redirect", 32'(REDIRECT), 32'(m_busy));
      chk("m_flush", 32'(FLUSH), m_busy ? 32'h7 : 32'h0);
      chk("m_pc", REDIRECT_PC, m_pc);
      chk("m_mis", 32'(MISALIGNED), 32'(m_mis));
      chk("m_brcnt", 32'(BR_COUNT), STATS ? m_bc : 0);
      chk("m_tkcnt", 32'(BR_TAKEN_COUNT), STATS ? m_tc : 0);
    end
  end

  task automatic cyc(input logic rst, input logic v,
                     input logic [3:0] sel, input logic tk,
                     input logic [31:0] tgt, input logic st);
    RESET = rst; EX_VALID = v; BRANCH_SELECT = sel;
    BRANCH_TAKEN = tk; EX_TARGET = tgt; STALL = st;
    @(posedge CLK);
    #1;
  endtask

  task automatic bubble();
    cyc(0, 0, 4'h0, 0, 32'h0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 4'h0, 0, 32'h0, 0);
  endtask

  initial begin
    // reset with random inputs
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom), 4'($urandom), 1'($urandom),
          $urandom, 1'($urandom));
    chk("rst_redirect", 32'(REDIRECT), 32'h0);
    chk("rst_flush", 32'(FLUSH), 32'h0);
    chk("rst_pc", REDIRECT_PC, 32'h0);
    chk("rst_cnt", 32'(BR_COUNT), 32'h0);

    // taken BEQ: one-cycle redirect
    bubble();
    cyc(0, 1, 4'b1000, 1, 32'h40, 0);
    chk("beq_redirect", 32'(REDIRECT), 32'h1);
    chk("beq_flush", 32'(FLUSH), 32'h7);
    chk("beq_pc", REDIRECT_PC, 32'h40);
    chk("beq_cnt", 32'(BR_COUNT), STATS ? 32'h1 : 32'h0);
    bubble();
    chk("beq_drop", 32'(REDIRECT), 32'h0);

    // not-taken BNE then stalled JAL
    do_reset();
    cyc(0, 1, 4'b1001, 0, 32'h80, 0);
    chk("bne_redirect", 32'(REDIRECT), 32'h0);
    chk("bne_cnt", 32'(BR_COUNT), STATS ? 32'h1 : 32'h0);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 4'b1010, 1, 32'h100, 1);
    chk("jal_stalled", 32'(REDIRECT), 32'h0);
    chk("jal_stall_cnt", 32'(BR_COUNT), STATS ? 32'h1 : 32'h0);
    cyc(0, 1, 4'b1010, 1, 32'h100, 0);
    chk("jal_redirect", 32'(REDIRECT), 32'h1);
    chk("jal_pc", REDIRECT_PC, 32'h100);
    chk("jal_cnt", 32'(BR_COUNT), STATS ? 32'h2 : 32'h0);
    bubble();
    chk("jal_drop", 32'(REDIRECT), 32'h0);

    // stall during redirect with wrong-path branch in EX
    do_reset();
    cyc(0, 1, 4'b1110, 1, 32'h2001, 0);
    chk("bltu_pc", REDIRECT_PC, 32'h2000);
    cyc(0, 1, 4'b1000, 1, 32'h500, 1);
    cyc(0, 1, 4'b1000, 1, 32'h500, 1);
    chk("hold_redirect", 32'(REDIRECT), 32'h1);
    chk("hold_pc", REDIRECT_PC, 32'h2000);
    chk("hold_mis", 32'(MISALIGNED), 32'h0);
    cyc(0, 1, 4'b1000, 1, 32'h500, 0);
    chk("hold_exit", 32'(REDIRECT), 32'h0);
    chk("wrongpath_pc", REDIRECT_PC, 32'h2000);
    chk("wrongpath_cnt", 32'(BR_TAKEN_COUNT),
        STATS ? 32'h1 : 32'h0);
    bubble();

    // misaligned JALR then reset mid-redirect
    do_reset();
    cyc(0, 1, 4'b1010, 1, 32'h106, 0);
    chk("jalr_mis", 32'(MISALIGNED), 32'h1);
    chk("jalr_pc", REDIRECT_PC, 32'h106);
    cyc(0, 1, 4'b1000, 1, 32'h44, 1);
    chk("jalr_hold_mis", 32'(MISALIGNED), 32'h1);
    cyc(1, 1, 4'b1000, 1, 32'h44, 1);
    chk("rstmid_redirect", 32'(REDIRECT), 32'h0);
    chk("rstmid_mis", 32'(MISALIGNED), 32'h0);
    chk("rstmid_pc", REDIRECT_PC, 32'h0);
    bubble();
    chk("rstmid_after", 32'(REDIRECT), 32'h0);

    // non-branches: reserved 011, bit3 low, bubble
    cyc(0, 1, 4'b1011, 1, 32'h300, 0);
    cyc(0, 1, 4'b0000, 1, 32'h300, 0);
    cyc(0, 0, 4'b1000, 1, 32'h300, 0);
    chk("nonbr_redirect", 32'(REDIRECT), 32'h0);
    chk("nonbr_cnt", 32'(BR_COUNT), 32'h0);

    // saturation: 20 taken branches
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 4'b1101, 1, 32'(i * 8), 0);
      bubble();
    end
    chk("sat_br", 32'(BR_COUNT), STATS ? 32'hF : 32'h0);
    chk("sat_tk", 32'(BR_TAKEN_COUNT), STATS ? 32'hF : 32'h0);
    chk("sat_pc", REDIRECT_PC, 32'h98);

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_redirect_controller.md
# branch_redirect_controller

Sequences control-flow redirection for the RV32IM five-stage pipeline. It samples the branch/jump decision produced in EX at each clock edge. On a taken branch or jump it issues a registered PC redirect and flushes the three younger wrong-path stages. It then holds that request across memory stalls until the pipeline accepts it. It sits between the EX-stage branch comparison logic and the PC mux / pipeline-register flush inputs.

## Interface
- STATS_WIDTH, 32: width of the branch statistics counters.

- CLK  in  1  pipeline clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- EX_VALID  in  1  EX holds a real instruction (not a bubble).
- BRANCH_SELECT  in  4  EX branch select. Bit3 = branch/jump; [2:0] = funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU); 010 = JAL/JALR.
- BRANCH_TAKEN  in  1  comparison result for the EX instruction; settled before the edge.
- EX_TARGET  in  32  computed target address (PC+imm or rs1+imm).
- STALL  in  1  pipeline-wide stall; pipeline registers hold while high.
- REDIRECT  out  1  PC mux select: load REDIRECT_PC.
- REDIRECT_PC  out  32  redirect target, with bit0 forced to 0.
- FLUSH  out  3  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM: bubble-insert on next accepted edge.
- MISALIGNED  out  1  redirect target has bit1 set (instruction-address-misaligned).
- BR_COUNT  out  STATS_WIDTH  resolved branch/jump count.
- BR_TAKEN_COUNT  out  STATS_WIDTH  taken branch/jump count.

## Operation
- Resolve condition (R): state IDLE, STALL=0, EX_VALID=1, BRANCH_SELECT[3]=1.
- Taken condition (T): R and BRANCH_TAKEN=1.
- Encodings 011 with bit3=1 are not branches and never satisfy R.
- FSM states: IDLE, REDIRECT.
- IDLE → REDIRECT on T. In the same edge, register REDIRECT_PC = {EX_TARGET[31:1],1'b0} and MISALIGNED = EX_TARGET[1].
- Not-taken resolution (R, not T): stay in IDLE; no outputs change.
- In REDIRECT, the outputs are REDIRECT=1, FLUSH=3'b111, and REDIRECT_PC and MISALIGNED held at their latched values.
- EX contents are ignored in REDIRECT, because EX then holds a wrong-path instruction. A wrong-path branch must never fire or be counted.
- REDIRECT → IDLE on the first edge with STALL=0, which is the edge where the pipeline accepts the redirect and flush.
- While STALL=1, REDIRECT holds with every output unchanged.
- In IDLE: REDIRECT=0, FLUSH=0, MISALIGNED=0. REDIRECT_PC keeps its last value.
- A branch held in EX by STALL=1 is not evaluated until the stall drops, so it is counted exactly once.
- MISALIGNED is a flag only; the redirect still occurs. Trap handling is downstream.

## Timing
- Reset values: state IDLE, REDIRECT=0, FLUSH=3'b000, MISALIGNED=0, REDIRECT_PC=32'h0, both counters 0.
- RESET has priority over all other inputs. RESET during REDIRECT drops every output to its reset value on that edge, and any pending redirect is discarded.
- Latency: T sampled at edge k; REDIRECT/FLUSH are high for cycle k..k+1. With no stall, they deassert at edge k+1.
- Minimum REDIRECT pulse: 1 cycle. Length is 1 + the number of consecutive stall cycles that start in the redirect cycle.
- Back-to-back taken branches are impossible to fire: the cycle after REDIRECT exits, EX holds a flushed bubble.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- BRANCH_STATS_EN defined: counters are active.
  - BR_COUNT increments on each R.
  - BR_TAKEN_COUNT increments on each T.
  - Both saturate at all-ones (no wrap) and clear only on RESET.
- BRANCH_STATS_EN undefined: counter registers are not built; BR_COUNT and BR_TAKEN_COUNT are tied to 0. FSM behaviour is identical.

## Test plan
- Reset then idle: RESET=1 for 2 cycles with random inputs → all outputs 0, REDIRECT_PC=0.
- Taken BEQ: EX_VALID=1, BRANCH_SELECT=4'b1000, BRANCH_TAKEN=1, EX_TARGET=32'h0000_0040, STALL=0 → for exactly 1 cycle REDIRECT=1, FLUSH=3'b111, REDIRECT_PC=32'h40, MISALIGNED=0. With stats on: BR_COUNT=1, BR_TAKEN_COUNT=1.
- Not-taken BNE then stalled JAL:
  - BNE (4'b1001, TAKEN=0) → no redirect, BR_COUNT=1.
  - JAL (4'b1010, TAKEN=1, target 32'h100) while STALL=1 for 3 cycles → no action and no count until STALL=0.
  - After STALL drops → 1-cycle redirect to 32'h100, BR_COUNT=2.
- Stall during redirect: taken BLTU to 32'h0000_2001, then STALL=1 for 2 cycles → REDIRECT held 3 cycles, REDIRECT_PC=32'h2000, MISALIGNED=0. A wrong-path taken branch presented in EX meanwhile is ignored and not counted.
- Misaligned JALR plus reset: taken 4'b1010 to 32'h0000_0106 → MISALIGNED=1, REDIRECT_PC=32'h106. With STALL=1, assert RESET mid-REDIRECT → next cycle all outputs 0 and state IDLE.
- Saturation (STATS_WIDTH=4, BRANCH_STATS_EN defined): 20 taken branches → BR_COUNT=BR_TAKEN_COUNT=4'hF. Without the macro, both read 0 throughout.
